sample_recorder: RTL and testbench

- Capture/playback buffer on the input side of the effects chain. It records 12-bit signed AC97 samples into on-chip memory.
- On playback it replays them as a paced sample stream: samples_out plus a one-cycle new_sample_ready strobe per AC97 frame.
- That stream feeds the effects-chain controller, which starts its chain on playback && new_sample_ready.

---
 rtl/sample_recorder_pkg.sv | 10 +
 rtl/sample_recorder_if.sv | 29 ++
 rtl/sample_bram.sv | 20 ++
 rtl/sample_recorder.sv | 118 +++++++++++
 tb/tb_sample_recorder.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sample_recorder_pkg.sv
// Shared audio definitions for the capture/playback buffer: FSM encoding and
// default sample and buffer sizes.
package sample_recorder_pkg;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RECORD = 2'd1;
  localparam logic [1:0] ST_PLAY   = 2'd2;

  localparam int SAMPLE_WIDTH       = 12;
  localparam int DEFAULT_ADDR_WIDTH = 16;
endpackage

// File: rtl/sample_recorder_if.sv
// Control, AC97 input and playback stream signals of the sample recorder.
interface sample_recorder_if
  import sample_recorder_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = SAMPLE_WIDTH
);
  logic                         record;
  logic                         playback;
  logic                         loop_enable;
  logic                         ac97_ready;
  logic signed [DATA_WIDTH-1:0] from_ac97_data;
  logic signed [DATA_WIDTH-1:0] samples_out;
  logic                         new_sample_ready;
  logic                         recording;
  logic                         playing;
  logic                         buffer_full;
  logic [ADDR_WIDTH:0]          length;

  modport master (
    output record, playback, loop_enable, ac97_ready, from_ac97_data,
    input  samples_out, new_sample_ready, recording, playing, buffer_full, length
  );

  modport slave (
    input  record, playback, loop_enable, ac97_ready, from_ac97_data,
    output samples_out, new_sample_ready, recording, playing, buffer_full, length
  );
endinterface

// File: rtl/sample_bram.sv
// Single-port sample RAM with registered read; maps onto a block RAM.
module sample_bram
  import sample_recorder_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = SAMPLE_WIDTH
) (
  input  logic                         clock,
  input  logic                         we,
  input  logic [ADDR_WIDTH-1:0]        addr,
  input  logic signed [DATA_WIDTH-1:0] din,
  output logic signed [DATA_WIDTH-1:0] dout
);
  logic signed [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clock) begin
    if (we) mem[addr] <= din;
    dout <= mem[addr];
  end
endmodule

// File: rtl/sample_recorder.sv
// Records AC97 samples into RAM and replays them as a paced stream with a
// fixed two-cycle strobe latency after each ac97_ready.
module sample_recorder
  import sample_recorder_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = SAMPLE_WIDTH
) (
  input logic              clock,
  input logic              reset,
  sample_recorder_if.slave bus
);
  localparam logic [ADDR_WIDTH:0] LAST_LEN = {1'b0, {ADDR_WIDTH{1'b1}}};

  logic [1:0]                   state;
  logic                         record_q, playback_q;
  logic                         rec_rise, play_rise;
  logic [ADDR_WIDTH-1:0]        wr_addr, rd_addr, mem_addr;
  logic [ADDR_WIDTH:0]          length_r;
  logic                         buffer_full_r;
  logic                         draining;
  logic                         we, issue, last_addr;
  logic                         vld_p0, vld_p1;
  logic signed [DATA_WIDTH-1:0] rd_data_p0, samples_p1;

  assign rec_rise  = bus.record & ~record_q;
  assign play_rise = bus.playback & ~playback_q;
  assign we        = (state == ST_RECORD) && bus.record && bus.ac97_ready;
  assign issue     = (state == ST_PLAY) && bus.playback && bus.ac97_ready && !draining;
  assign last_addr = ({1'b0, rd_addr} == (length_r - 1'b1));
  assign mem_addr  = (state == ST_RECORD) ? wr_addr : rd_addr;

  sample_bram #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_bram (
    .clock (clock),
    .we    (we),
    .addr  (mem_addr),
    .din   (bus.from_ac97_data),
    .dout  (rd_data_p0)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= ST_IDLE;
      record_q      <= 1'b0;
      playback_q    <= 1'b0;
      wr_addr       <= '0;
      rd_addr       <= '0;
      length_r      <= '0;
      buffer_full_r <= 1'b0;
      draining      <= 1'b0;
      vld_p0        <= 1'b0;
      vld_p1        <= 1'b0;
      samples_p1    <= '0;
    end else begin
      record_q   <= bus.record;
      playback_q <= bus.playback;
      // p0: read issued this cycle, RAM data appears next cycle
      vld_p0 <= issue;
      // p1: capture RAM data into the output register and strobe
      vld_p1 <= vld_p0;
      if (vld_p0) samples_p1 <= rd_data_p0;

      case (state)
        ST_IDLE: begin
          if (rec_rise) begin
            state         <= ST_RECORD;
            wr_addr       <= '0;
            length_r      <= '0;
            buffer_full_r <= 1'b0;
          end else if (play_rise && (length_r != '0) && !bus.record) begin
            state    <= ST_PLAY;
            rd_addr  <= '0;
            draining <= 1'b0;
          end
        end
        ST_RECORD: begin
          if (!bus.record) begin
            state <= ST_IDLE;
          end else if (bus.ac97_ready) begin
            wr_addr  <= wr_addr + 1'b1;
            length_r <= length_r + 1'b1;
            if (length_r == LAST_LEN) begin
              buffer_full_r <= 1'b1;
              state         <= ST_IDLE;
            end
          end
        end
        ST_PLAY: begin
          if (!bus.playback) begin
            // abort drops anything still in the read pipeline
            state    <= ST_IDLE;
            vld_p0   <= 1'b0;
            vld_p1   <= 1'b0;
            draining <= 1'b0;
          end else begin
            if (issue) begin
              if (!last_addr)           rd_addr  <= rd_addr + 1'b1;
              else if (bus.loop_enable) rd_addr  <= '0;
              else                      draining <= 1'b1;
            end
            if (draining && !vld_p0) begin
              state    <= ST_IDLE;
              draining <= 1'b0;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.samples_out      = samples_p1;
  assign bus.new_sample_ready = vld_p1;
  assign bus.recording        = (state == ST_RECORD);
  assign bus.playing          = (state == ST_PLAY);
  assign bus.buffer_full      = buffer_full_r;
  assign bus.length           = length_r;
endmodule

// File: tb/tb_sample_recorder.sv
// Bench for sample_recorder with a 16-entry buffer and a queue-based model of
// the recorded material.
module tb_sample_recorder;
  localparam int AW    = 4;
  localparam int DW    = 12;
  localparam int LW    = AW + 1;
  localparam int DEPTH = 1 << AW;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int vectors     = 0;
  int miscompares = 0;

  logic [DW-1:0] stim[$];
  logic [DW-1:0] recorded[$];

  sample_recorder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

  sample_recorder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic strobe(input logic [DW-1:0] d);
    bus.ac97_ready     = 1'b1;
    bus.from_ac97_data = d;
    tick();
    bus.ac97_ready = 1'b0;
  endtask

  // Records stim; the model keeps only what fits in the buffer.
  task automatic do_record(input int gap);
    bus.record = 1'b1;
    tick();
    foreach (stim[i]) begin
      strobe(stim[i]);
      repeat (gap) tick();
    end
    bus.record = 1'b0;
    tick();
    recorded = {};
    foreach (stim[i]) if (i < DEPTH) recorded.push_back(stim[i]);
  endtask

  // Plays n strobes spaced 3+gap cycles; each must come back two cycles later.
  task automatic run_playback(input int n, input bit lp, input int gap);
    int len;
    len = recorded.size();
    bus.loop_enable = lp;
    bus.playback    = 1'b1;
    tick();
    for (int i = 0; i < n; i++) begin
      logic [DW-1:0] expv;
      expv = recorded[i % len];
      strobe(DW'($urandom));
      vectors++;
      if (bus.new_sample_ready !== 1'b0) begin
        $display("FAIL play_early[%0d] strobe=%b required=0", i, bus.new_sample_ready);
        miscompares++;
      end
      tick();
      vectors++;
      if (bus.new_sample_ready !== 1'b1 || bus.samples_out !== expv) begin
        $display("FAIL play_sample[%0d] strobe=%b data=%h required strobe=1 data=%h",
                 i, bus.new_sample_ready, bus.samples_out, expv);
        miscompares++;
      end
      tick();
      vectors++;
      if (bus.new_sample_ready !== 1'b0 || bus.samples_out !== expv) begin
        $display("FAIL play_hold[%0d] strobe=%b data=%h required strobe=0 data=%h",
                 i, bus.new_sample_ready, bus.samples_out, expv);
        miscompares++;
      end
      repeat (gap) tick();
    end
  endtask

  task automatic test_reset();
    reset        = 1'b0;
    bus.playback = 1'b1;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    strobe(12'h555);
    for (int c = 0; c < 3; c++) begin
      vectors++;
      if (bus.new_sample_ready !== 1'b0 || bus.playing !== 1'b0 || bus.recording !== 1'b0 ||
          bus.buffer_full !== 1'b0 || bus.length !== '0 || bus.samples_out !== '0) begin
        $display("FAIL reset_state[%0d] nsr=%b play=%b rec=%b full=%b len=%0d out=%h required all 0",
                 c, bus.new_sample_ready, bus.playing, bus.recording, bus.buffer_full,
                 bus.length, bus.samples_out);
        miscompares++;
      end
      tick();
    end
    bus.playback = 1'b0;
    tick();
  endtask

  task automatic test_record_play();
    stim = '{12'h001, 12'h7FF, 12'h800, 12'hFFF, 12'h123};
    do_record(1);
    vectors++;
    if (bus.length !== LW'(5) || bus.buffer_full !== 1'b0 || bus.recording !== 1'b0) begin
      $display("FAIL rp_length len=%0d full=%b rec=%b required 5/0/0",
               bus.length, bus.buffer_full, bus.recording);
      miscompares++;
    end
    run_playback(5, 1'b0, 7);
    tick();
    vectors++;
    if (bus.playing !== 1'b0) begin
      $display("FAIL rp_done playing=%b required 0", bus.playing);
      miscompares++;
    end
    bus.playback = 1'b0;
    tick();
  endtask

  task automatic test_loop();
    run_playback(7, 1'b1, 7);
    vectors++;
    if (bus.playing !== 1'b1) begin
      $display("FAIL loop_playing playing=%b required 1", bus.playing);
      miscompares++;
    end
    bus.playback    = 1'b0;
    bus.loop_enable = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_full();
    stim = {};
    for (int i = 0; i < 20; i++) stim.push_back(DW'($urandom));
    bus.record = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) begin
      strobe(stim[i]);
      if (i == 14) begin
        vectors++;
        if (bus.recording !== 1'b1 || bus.buffer_full !== 1'b0) begin
          $display("FAIL full_before rec=%b full=%b required 1/0", bus.recording, bus.buffer_full);
          miscompares++;
        end
      end
      if (i == 15) begin
        vectors++;
        if (bus.recording !== 1'b0 || bus.buffer_full !== 1'b1 || bus.length !== LW'(DEPTH)) begin
          $display("FAIL full_hit rec=%b full=%b len=%0d required 0/1/%0d",
                   bus.recording, bus.buffer_full, bus.length, DEPTH);
          miscompares++;
        end
      end
      tick();
    end
    bus.record = 1'b0;
    tick();
    recorded = {};
    for (int i = 0; i < DEPTH; i++) recorded.push_back(stim[i]);
    vectors++;
    if (bus.length !== LW'(DEPTH) || bus.buffer_full !== 1'b1) begin
      $display("FAIL full_after len=%0d full=%b required %0d/1", bus.length, bus.buffer_full, DEPTH);
      miscompares++;
    end
    run_playback(DEPTH, 1'b0, 0);
    tick();
    vectors++;
    if (bus.playing !== 1'b0) begin
      $display("FAIL full_done playing=%b required 0", bus.playing);
      miscompares++;
    end
    bus.playback = 1'b0;
    tick();
  endtask

  task automatic test_priority_abort();
    bus.record   = 1'b1;
    bus.playback = 1'b1;
    tick();
    vectors++;
    if (bus.recording !== 1'b1 || bus.playing !== 1'b0) begin
      $display("FAIL prio rec=%b play=%b required 1/0", bus.recording, bus.playing);
      miscompares++;
    end
    bus.record   = 1'b0;
    bus.playback = 1'b0;
    tick();
    tick();
    bus.playback = 1'b1;
    tick();
    tick();
    vectors++;
    if (bus.playing !== 1'b0 || bus.length !== '0) begin
      $display("FAIL empty_play play=%b len=%0d required 0/0", bus.playing, bus.length);
      miscompares++;
    end
    strobe(12'h3C3);
    for (int c = 0; c < 3; c++) begin
      vectors++;
      if (bus.new_sample_ready !== 1'b0) begin
        $display("FAIL empty_strobe[%0d] nsr=%b required 0", c, bus.new_sample_ready);
        miscompares++;
      end
      tick();
    end
    bus.playback = 1'b0;
    tick();

    stim = '{12'h111, 12'h222, 12'h333};
    do_record(0);
    bus.playback = 1'b1;
    tick();
    strobe(12'h000);
    bus.playback = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      vectors++;
      if (bus.new_sample_ready !== 1'b0 || bus.playing !== 1'b0) begin
        $display("FAIL abort[%0d] nsr=%b play=%b required 0/0", c, bus.new_sample_ready, bus.playing);
        miscompares++;
      end
    end
  endtask

  task automatic test_back_to_back();
    stim = {};
    for (int i = 0; i < 5; i++) stim.push_back(DW'($urandom));
    do_record(0);
    bus.loop_enable = 1'b0;
    bus.playback    = 1'b1;
    tick();
    bus.ac97_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      bus.from_ac97_data = DW'($urandom);
      tick();
      if (c == 2) bus.ac97_ready = 1'b0;
      vectors++;
      if (c >= 1 && c <= 3) begin
        if (bus.new_sample_ready !== 1'b1 || bus.samples_out !== recorded[c-1]) begin
          $display("FAIL b2b[%0d] nsr=%b data=%h required 1/%h",
                   c, bus.new_sample_ready, bus.samples_out, recorded[c-1]);
          miscompares++;
        end
      end else if (bus.new_sample_ready !== 1'b0) begin
        $display("FAIL b2b_idle[%0d] nsr=%b required 0", c, bus.new_sample_ready);
        miscompares++;
      end
    end
    vectors++;
    if (bus.playing !== 1'b1) begin
      $display("FAIL b2b_playing playing=%b required 1", bus.playing);
      miscompares++;
    end
    bus.playback = 1'b0;
    tick();
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      int n;
      int plays;
      bit lp;
      n  = $urandom_range(1, DEPTH);
      lp = 1'($urandom_range(0, 1));
      stim = {};
      for (int i = 0; i < n; i++) stim.push_back(DW'($urandom));
      do_record($urandom_range(0, 3));
      vectors++;
      if (bus.length !== LW'(n) || bus.buffer_full !== (n == DEPTH)) begin
        $display("FAIL rnd_length[%0d] len=%0d full=%b required %0d/%b",
                 it, bus.length, bus.buffer_full, n, (n == DEPTH));
        miscompares++;
      end
      plays = lp ? n + $urandom_range(1, 6) : n;
      run_playback(plays, lp, $urandom_range(0, 4));
      tick();
      vectors++;
      if (bus.playing !== lp) begin
        $display("FAIL rnd_playing[%0d] playing=%b required %b", it, bus.playing, lp);
        miscompares++;
      end
      bus.playback = 1'b0;
      tick();
      tick();
    end
  endtask

  initial begin
    bus.record         = 1'b0;
    bus.playback       = 1'b0;
    bus.loop_enable    = 1'b0;
    bus.ac97_ready     = 1'b0;
    bus.from_ac97_data = '0;
    test_reset();
    test_record_play();
    test_loop();
    test_full();
    test_priority_abort();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
